// File: rtl/dram_req_arbiter.sv
// dram_req_arbiter: shares one DRAM controller port among NUM_REQ requesters.
// Round-robin pick, one-cycle D_REQ pulse, grant held until the burst has moved.
//
// Ports:
//   CLK, RST            USERCLK and synchronous active-high reset
//   R_REQ/R_INITADR/    per-requester command, start address, element count
//   R_ELEM/R_DIN        and write data (slice i belongs to requester i)
//   R_GRANT/R_DONE      one-hot grant and one-cycle completion pulse
//   R_W/R_DOUTEN/R_DOUT write-accept and read-valid strobes for the winner,
//                       read data broadcast
//   D_*                 controller command/data port
//
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index
// wins, higher indices may starve). Default is round-robin.

`ifndef APPDATA_WIDTH
`define APPDATA_WIDTH 512
`endif
`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif

module dram_req_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = `APPDATA_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [2*NUM_REQ-1:0]      R_REQ,
    input  logic [32*NUM_REQ-1:0]     R_INITADR,
    input  logic [32*NUM_REQ-1:0]     R_ELEM,
    input  logic [DATA_W*NUM_REQ-1:0] R_DIN,
    output logic [NUM_REQ-1:0]        R_GRANT,
    output logic [NUM_REQ-1:0]        R_W,
    output logic [DATA_W-1:0]         R_DOUT,
    output logic [NUM_REQ-1:0]        R_DOUTEN,
    output logic [NUM_REQ-1:0]        R_DONE,
    output logic [1:0]                D_REQ,
    output logic [31:0]               D_INITADR,
    output logic [31:0]               D_ELEM,
    output logic [DATA_W-1:0]         D_DIN,
    input  logic                      D_W,
    input  logic [DATA_W-1:0]         D_DOUT,
    input  logic                      D_DOUTEN,
    input  logic                      D_BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] REQ_WRITE = `DRAM_REQ_WRITE;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     win_q, win_d;
    logic [1:0]           code_q, code_d;
    logic [31:0]          adr_q, adr_d;
    logic [31:0]          elem_q, elem_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [1:0]           dreq_q, dreq_d;

    logic [NUM_REQ-1:0]   req_any;
    logic                 hit;
    logic [IDX_W-1:0]     pick;
    logic [1:0]           sel_code;
    logic [31:0]          sel_adr;
    logic [31:0]          sel_elem;
    logic [NUM_REQ-1:0]   sel_oh;
    logic                 inc;

    always_comb begin
        req_any = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_any[i] = |R_REQ[2*i +: 2];
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_any[i]) begin
                hit  = 1'b1;
                pick = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] scan_idx;

    // Scan offsets NUM_REQ..1 from the pointer; the last hit written is
    // the one closest after the pointer, so the previous winner goes last.
    always_comb begin
        hit      = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_any[scan_idx]) begin
                hit  = 1'b1;
                pick = scan_idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && hit && !D_BUSY) begin
            ptr_d = pick;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= IDX_W'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        sel_code = '0;
        sel_adr  = '0;
        sel_elem = '0;
        sel_oh   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == IDX_W'(i)) begin
                sel_code  = R_REQ[2*i +: 2];
                sel_adr   = R_INITADR[32*i +: 32];
                sel_elem  = R_ELEM[32*i +: 32];
                sel_oh[i] = 1'b1;
            end
        end
    end

    // Only the strobe matching the latched direction advances the burst.
    assign inc = (code_q == REQ_WRITE) ? D_W : D_DOUTEN;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        code_d  = code_q;
        adr_d   = adr_q;
        elem_d  = elem_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        dreq_d  = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (hit && !D_BUSY) begin
                    win_d   = pick;
                    code_d  = sel_code;
                    adr_d   = sel_adr;
                    elem_d  = sel_elem;
                    grant_d = sel_oh;
                    if (sel_elem == 32'd0) begin
                        state_d = DONE;
                    end else begin
                        dreq_d  = sel_code;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = RUN;
            end
            RUN: begin
                // Saturate rather than wrap on a misbehaving controller.
                if (inc && cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (cnt_d == elem_q && !D_BUSY) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            win_q   <= '0;
            code_q  <= '0;
            adr_q   <= '0;
            elem_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            dreq_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            code_q  <= code_d;
            adr_q   <= adr_d;
            elem_q  <= elem_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            dreq_q  <= dreq_d;
        end
    end

    always_comb begin
        D_DIN = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_q == IDX_W'(i)) begin
                D_DIN = R_DIN[DATA_W*i +: DATA_W];
            end
        end
    end

    assign R_GRANT   = grant_q;
    assign R_DONE    = (state_q == DONE) ? grant_q : '0;
    assign R_W       = {NUM_REQ{D_W}} & grant_q;
    assign R_DOUTEN  = {NUM_REQ{D_DOUTEN}} & grant_q;
    assign R_DOUT    = D_DOUT;
    assign D_REQ     = dreq_q;
    assign D_INITADR = adr_q;
    assign D_ELEM    = elem_q;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb_dram_req_arbiter: directed scoreboard bench for dram_req_arbiter.
// Stimulus pushes timed expectations; a negedge monitor pops on DUT events.

`ifndef DRAM_REQ_READ
`define DRAM_REQ_READ 2'b01
`endif
`ifndef DRAM_REQ_WRITE
`define DRAM_REQ_WRITE 2'b10
`endif

module tb_dram_req_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam logic [1:0] RD = `DRAM_REQ_READ;
    localparam logic [1:0] WR = `DRAM_REQ_WRITE;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2*N-1:0]    r_req = '0;
    logic [32*N-1:0]   r_initadr = '0;
    logic [32*N-1:0]   r_elem = '0;
    logic [DW*N-1:0]   r_din = '0;
    logic [N-1:0]      r_grant;
    logic [N-1:0]      r_w;
    logic [DW-1:0]     r_dout;
    logic [N-1:0]      r_douten;
    logic [N-1:0]      r_done;
    logic [1:0]        d_req;
    logic [31:0]       d_initadr;
    logic [31:0]       d_elem;
    logic [DW-1:0]     d_din;
    logic              d_w = 1'b0;
    logic [DW-1:0]     d_dout = '0;
    logic              d_douten = 1'b0;
    logic              d_busy = 1'b0;

    dram_req_arbiter #(
        .NUM_REQ (N),
        .IDX_W   (2),
        .DATA_W  (DW)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .R_REQ     (r_req),
        .R_INITADR (r_initadr),
        .R_ELEM    (r_elem),
        .R_DIN     (r_din),
        .R_GRANT   (r_grant),
        .R_W       (r_w),
        .R_DOUT    (r_dout),
        .R_DOUTEN  (r_douten),
        .R_DONE    (r_done),
        .D_REQ     (d_req),
        .D_INITADR (d_initadr),
        .D_ELEM    (d_elem),
        .D_DIN     (d_din),
        .D_W       (d_w),
        .D_DOUT    (d_dout),
        .D_DOUTEN  (d_douten),
        .D_BUSY    (d_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [N-1:0] g;
        logic [1:0]  dreq;
        logic [31:0] adr;
        logic [31:0] elem;
        logic [N-1:0] rw;
        logic [N-1:0] rden;
        logic [N-1:0] rdone;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
    } exp_t;

    exp_t          q[$];
    exp_t          e;
    int            nvec = 0;
    int            nbad = 0;
    bit            mon_en = 1'b0;
    bit            ok;
    logic [N-1:0]  prev_g = '0;

    always @(negedge clk) begin
        if (mon_en && (r_grant != prev_g || d_req != 2'b00 ||
                       r_done != '0 || r_w != '0 || r_douten != '0)) begin
            nvec++;
            if (q.size() == 0) begin
                nbad++;
                $display("FAIL unexpected_event cyc=%0d got g=%b dreq=%0d rw=%b rden=%b done=%b, required no event",
                         cyc, r_grant, d_req, r_w, r_douten, r_done);
            end else begin
                e = q.pop_front();
                ok = (cyc == e.c) && (r_grant == e.g) && (d_req == e.dreq) &&
                     (r_w == e.rw) && (r_douten == e.rden) && (r_done == e.rdone) &&
                     (e.dreq == 2'b00 || (d_initadr == e.adr && d_elem == e.elem)) &&
                     (e.rw == '0 || d_din == e.din) &&
                     (e.rden == '0 || r_dout == e.dout);
                if (!ok) begin
                    nbad++;
                    $display("FAIL event got cyc=%0d g=%b dreq=%0d adr=%h elem=%0d rw=%b rden=%b done=%b din=%h dout=%h required cyc=%0d g=%b dreq=%0d adr=%h elem=%0d rw=%b rden=%b done=%b din=%h dout=%h",
                             cyc, r_grant, d_req, d_initadr, d_elem, r_w, r_douten, r_done, d_din, r_dout,
                             e.c, e.g, e.dreq, e.adr, e.elem, e.rw, e.rden, e.rdone, e.din, e.dout);
                end
            end
        end
        prev_g = r_grant;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push(input int c, input logic [N-1:0] g, input logic [1:0] dreq,
                        input logic [31:0] adr, input logic [31:0] elem,
                        input logic [N-1:0] rw, input logic [N-1:0] rden,
                        input logic [N-1:0] rdone, input logic [DW-1:0] din,
                        input logic [DW-1:0] dout);
        exp_t x;
        x.c = c; x.g = g; x.dreq = dreq; x.adr = adr; x.elem = elem;
        x.rw = rw; x.rden = rden; x.rdone = rdone; x.din = din; x.dout = dout;
        q.push_back(x);
    endtask

    task automatic set_req(input int i, input logic [1:0] code,
                           input logic [31:0] adr, input logic [31:0] elem);
        r_req[2*i +: 2]      = code;
        r_initadr[32*i +: 32] = adr;
        r_elem[32*i +: 32]    = elem;
    endtask

    function automatic logic [DW-1:0] din_pat(input int i, input int k);
        return DW'(32'hD000_0000 | (i << 16) | k);
    endfunction

    // Plays the controller for one element.
    task automatic beat(input int idx, input logic [1:0] code, input int k, input bit last);
        logic [N-1:0] g;
        g = oh(idx);
        for (int i = 0; i < N; i++) r_din[DW*i +: DW] = din_pat(i, k);
        d_dout = DW'(32'hBEEF_0000 | k);
        if (code == WR) d_w = 1'b1;
        else d_douten = 1'b1;
        if (last) d_busy = 1'b0;
        push(cyc, g, 2'b00, 32'd0, 32'd0,
             (code == WR) ? g : '0, (code == WR) ? '0 : g, '0,
             din_pat(idx, k), DW'(32'hBEEF_0000 | k));
        tick();
        d_w = 1'b0;
        d_douten = 1'b0;
    endtask

    // Call in an IDLE cycle with the request already driven and D_BUSY low.
    // Returns in the IDLE cycle where the grant has just dropped.
    task automatic run_burst(input int idx, input logic [1:0] code,
                             input logic [31:0] adr, input logic [31:0] elem,
                             input bit drop);
        int c;
        logic [N-1:0] g;
        c = cyc;
        g = oh(idx);
        if (elem == 32'd0) begin
            push(c + 1, g, 2'b00, 0, 0, '0, '0, g, '0, '0);
            push(c + 2, '0, 2'b00, 0, 0, '0, '0, '0, '0, '0);
            tick();
            if (drop) r_req[2*idx +: 2] = 2'b00;
            tick();
        end else begin
            push(c + 1, g, code, adr, elem, '0, '0, '0, '0, '0);
            tick();
            if (drop) r_req[2*idx +: 2] = 2'b00;
            d_busy = 1'b1;
            tick();
            for (int k = 0; k < int'(elem); k++) begin
                beat(idx, code, k, k == int'(elem) - 1);
            end
            push(cyc, g, 2'b00, 0, 0, '0, '0, g, '0, '0);
            tick();
            push(cyc, '0, 2'b00, 0, 0, '0, '0, '0, '0, '0);
        end
    endtask

    initial begin
        int c;
        repeat (3) tick();
        nvec++;
        if (r_grant !== '0 || d_req !== 2'b00 || r_done !== '0 ||
            d_initadr !== 32'd0 || d_elem !== 32'd0) begin
            nbad++;
            $display("FAIL reset_state got g=%b dreq=%0d done=%b adr=%h elem=%0d required all zero",
                     r_grant, d_req, r_done, d_initadr, d_elem);
        end
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Single read burst by requester 0.
        set_req(0, RD, 32'h100, 32'd4);
        run_burst(0, RD, 32'h100, 32'd4, 1'b1);

`ifdef ARB_FIXED_PRIO_EN
        // Requesters 0 and 2 held: 0 wins every time.
        set_req(0, WR, 32'h400, 32'd2);
        set_req(2, WR, 32'h500, 32'd2);
        repeat (3) run_burst(0, WR, 32'h400, 32'd2, 1'b0);
        r_req = '0;
`else
        // Requesters 1 and 3 held: grants alternate 1,3,1,3.
        set_req(1, WR, 32'h200, 32'd2);
        set_req(3, WR, 32'h300, 32'd2);
        run_burst(1, WR, 32'h200, 32'd2, 1'b0);
        run_burst(3, WR, 32'h300, 32'd2, 1'b0);
        run_burst(1, WR, 32'h200, 32'd2, 1'b0);
        run_burst(3, WR, 32'h300, 32'd2, 1'b0);
        r_req = '0;
`endif

        // Zero-length burst: grant and done with no D_REQ.
        set_req(2, RD, 32'h600, 32'd0);
        run_burst(2, RD, 32'h600, 32'd0, 1'b1);

        // Busy controller holds off the grant.
        d_busy = 1'b1;
        set_req(0, RD, 32'h700, 32'd3);
        repeat (4) tick();
        d_busy = 1'b0;
        run_burst(0, RD, 32'h700, 32'd3, 1'b1);

        // Reset after 2 of 8 write elements.
        set_req(1, WR, 32'h800, 32'd8);
        c = cyc;
        push(c + 1, oh(1), WR, 32'h800, 32'd8, '0, '0, '0, '0, '0);
        tick();
        r_req[3:2] = 2'b00;
        d_busy = 1'b1;
        tick();
        beat(1, WR, 0, 1'b0);
        beat(1, WR, 1, 1'b0);
        rst = 1'b1;
        push(cyc + 1, '0, 2'b00, 0, 0, '0, '0, '0, '0, '0);
        tick();
        rst = 1'b0;
        d_busy = 1'b0;
        tick();

        // Fresh requests 0 and 2 after reset: 0 first, then 2.
        set_req(0, RD, 32'h900, 32'd1);
        set_req(2, RD, 32'hA00, 32'd1);
        run_burst(0, RD, 32'h900, 32'd1, 1'b1);
        run_burst(2, RD, 32'hA00, 32'd1, 1'b1);

        repeat (5) tick();
        mon_en = 1'b0;
        while (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            nvec++;
            nbad++;
            $display("FAIL missing_event got none required cyc=%0d g=%b dreq=%0d done=%b",
                     x.c, x.g, x.dreq, x.rdone);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Shares the single DRAM controller command/data port (D_REQ/D_INITADR/D_ELEM/D_DIN/D_W/D_DOUT/D_DOUTEN/D_BUSY) among NUM_REQ requesters, e.g. sorter-tree loaders and the result writer.
- Arbitrates round-robin and forwards the winner's burst request as a one-cycle D_REQ pulse.
- Holds the grant until every element of the burst has moved, while steering write strobes, write data and read-valid strobes to the granted requester only.
- Sits between the user logic and the DRAM controller, in the USERCLK domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- IDX_W, 2, width of the winner index; must be at least clog2(NUM_REQ).
- DATA_W, `APPDATA_WIDTH, width of one DRAM block.

Ports:
- CLK  in  1  USERCLK from the DRAM controller.
- RST  in  1  synchronous, active-high reset (the controller's RST_O).
- R_REQ  in  2*NUM_REQ  per-requester command, slice i = [2i+1:2i]; 2'b00 = idle, otherwise `DRAM_REQ_READ / `DRAM_REQ_WRITE.
- R_INITADR  in  32*NUM_REQ  per-requester initial block address.
- R_ELEM  in  32*NUM_REQ  per-requester element count.
- R_DIN  in  DATA_W*NUM_REQ  per-requester write data.
- R_GRANT  out  NUM_REQ  one-hot; set while requester i owns the port.
- R_W  out  NUM_REQ  write-element accept strobe, routed from D_W.
- R_DOUT  out  DATA_W  read data, broadcast to all requesters.
- R_DOUTEN  out  NUM_REQ  read-data valid, routed from D_DOUTEN.
- R_DONE  out  NUM_REQ  one-cycle pulse when requester i's burst completes.
- D_REQ  out  2  command to the controller.
- D_INITADR  out  32  address to the controller.
- D_ELEM  out  32  element count to the controller.
- D_DIN  out  DATA_W  write data to the controller.
- D_W  in  1  controller accepts one write element.
- D_DOUT  in  DATA_W  controller read data.
- D_DOUTEN  in  1  controller read data valid.
- D_BUSY  in  1  controller busy.

Behaviour:
- One clock CLK. RST is synchronous and active-high.
- Reset values:
  - state=IDLE; R_GRANT, R_DONE, D_REQ all 0.
  - D_INITADR=0, D_ELEM=0, element counter=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 wins first.
- State IDLE:
  - Each cycle, scan requesters whose R_REQ slice is nonzero, starting at pointer+1 and wrapping modulo NUM_REQ.
  - Pick the first hit, but only if D_BUSY=0.
  - On a pick: latch the winner index, code, address and count; set pointer=winner; set R_GRANT[winner].
  - If the latched count is 0: go to DONE without issuing D_REQ.
  - Otherwise: drive D_REQ=code, D_INITADR, D_ELEM and go to ISSUE.
  - With no requests, or D_BUSY=1: stay in IDLE.
- State ISSUE:
  - D_REQ is nonzero for exactly this one cycle.
  - Next cycle D_REQ=0 and state goes to RUN.
- State RUN:
  - Increment the counter on D_W (write) or D_DOUTEN (read).
  - When the counter reaches the latched count and D_BUSY=0 in the same cycle, go to DONE.
  - The compare uses the post-increment value, so a last element arriving with D_BUSY already low completes in that cycle.
- State DONE (1 cycle):
  - R_DONE[winner]=1. R_GRANT stays set this cycle.
  - Next cycle: clear R_GRANT, clear the counter, return to IDLE.
- Grant latency: R_GRANT rises 1 cycle after R_REQ is seen in IDLE.
- Back-to-back: the earliest next grant is 2 cycles after DONE.
- Combinational routing (no added latency):
  - R_W[i] = D_W & R_GRANT[i].
  - R_DOUTEN[i] = D_DOUTEN & R_GRANT[i].
  - D_DIN = R_DIN slice of the latched winner.
  - R_DOUT = D_DOUT.
- Requester contract:
  - Hold R_REQ, R_INITADR and R_ELEM stable until R_GRANT rises.
  - R_REQ must be 0 in the cycle after R_DONE unless a new burst is wanted; a still-nonzero R_REQ is treated as a new request.
- Request changes: changes on non-granted requesters are ignored until IDLE. Changes by the granted requester after the grant have no effect.
- Counter: 32-bit, never wraps; count values above 2^32-1 are not supported.
- Reset mid-burst: everything returns to reset values immediately. The controller shares the reset, so no partial-burst recovery is needed.

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index pending requester always wins, the pointer is unused, and a higher index can starve.
- Undefined (default): round-robin as specified in Behaviour.

Test Plan:
- Reset, then R_REQ[0]=READ, INITADR=0x100, ELEM=4 → R_GRANT=0001 at t+1; D_REQ=READ for 1 cycle only with D_INITADR=0x100, D_ELEM=4; 4 R_DOUTEN[0] pulses, R_DOUTEN[3:1]=0; R_DONE[0] pulse; grant drops.
- Requesters 1 and 3 both WRITE ELEM=2, issued repeatedly → grants alternate 1,3,1,3; R_W only on the granted index; D_DIN equals the granted R_DIN on every D_W cycle.
- Requester 2 requests ELEM=0 → grant then R_DONE[2] 1 cycle later; D_REQ never leaves 0.
- D_BUSY held at 1 when a request arrives → no grant until D_BUSY=0; then a grant follows 1 cycle later.
- RST asserted in RUN after 2 of 8 elements → next cycle R_GRANT=0, D_REQ=0, state IDLE; a fresh request is granted to requester 0 first.
- With ARB_FIXED_PRIO_EN, requesters 0 and 2 held continuously → requester 0 granted every time; R_DONE[2] never fires.
